// File: rtl/pipe3_core_p_if.sv
// Core-side bus of pipe3_core_p: instruction fetch port, run control and the
// pipeline observation outputs used by the harness.
interface pipe3_core_p_if #(
  parameter int DW = 16
);
  logic          run;
  logic [15:0]   imem_data;
  logic [DW-1:0] imem_addr;
  logic [DW-1:0] pc;
  logic [15:0]   ifid_ir;
  logic [15:0]   idex_ir;
  logic [DW-1:0] wd;
  logic [1:0]    wr;
  logic          we;

  modport master (
    input  run, imem_data,
    output imem_addr, pc, ifid_ir, idex_ir, wd, wr, we
  );

  modport slave (
    output run, imem_data,
    input  imem_addr, pc, ifid_ir, idex_ir, wd, wr, we
  );
endinterface

// File: rtl/pipe3_core_p.sv
// Three-stage (IF/ID/EX) MIPS-subset core, DW-bit datapath, falling-edge state,
// EX->ID forwarding and EX-resolved BEQ/BNE with a two-slot flush.
module pipe3_core_p #(
  parameter int            DW       = 16,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  pipe3_core_p_if.master bus
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [DW-1:0] PC_STEP = {{(DW-2){1'b0}}, 2'b10};

  function automatic logic writes_reg(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: writes_reg = 1'b1;
      default:                                        writes_reg = 1'b0;
    endcase
  endfunction

  logic [DW-1:0] pc_q, pc_d;
  logic [15:0]   ifid_ir_q, ifid_ir_d;
  logic [DW-1:0] ifid_pc_q, ifid_pc_d;
  logic [15:0]   idex_ir_q, idex_ir_d;
  logic [DW-1:0] idex_pc_q, idex_pc_d;
  logic [DW-1:0] idex_a_q, idex_a_d;
  logic [DW-1:0] idex_b_q, idex_b_d;
  logic [DW-1:0] idex_imm_q, idex_imm_d;
  logic          idex_rw_q, idex_rw_d;
  logic [1:0]    idex_wr_q, idex_wr_d;
  logic [DW-1:0] rf_q [4];

  // ID decode
  logic [3:0]    id_op;
  logic [1:0]    id_rs, id_rt, id_rd;
  logic [DW-1:0] id_imm, id_rs_val, id_rt_val;

  assign id_op  = ifid_ir_q[15:12];
  assign id_rs  = ifid_ir_q[11:10];
  assign id_rt  = ifid_ir_q[9:8];
  assign id_rd  = ifid_ir_q[7:6];
  assign id_imm = {{(DW-8){ifid_ir_q[7]}}, ifid_ir_q[7:0]};

  // EX
  logic [3:0]    ex_op;
  logic [DW-1:0] ex_wd, ex_target;
  logic          ex_taken;

  assign ex_op     = idex_ir_q[15:12];
  assign ex_target = idex_pc_q + PC_STEP + {idex_imm_q[DW-2:0], 1'b0};
  assign ex_taken  = ((ex_op == OP_BEQ) && (idex_a_q == idex_b_q)) ||
                     ((ex_op == OP_BNE) && (idex_a_q != idex_b_q));

  always_comb begin
    ex_wd = '0;
    case (ex_op)
      OP_ADD, OP_ADDI: ex_wd = idex_a_q + idex_b_q;
      OP_SUB:          ex_wd = idex_a_q - idex_b_q;
      OP_AND:          ex_wd = idex_a_q & idex_b_q;
      OP_OR:           ex_wd = idex_a_q | idex_b_q;
      OP_SLT:          ex_wd = {{(DW-1){1'b0}}, $signed(idex_a_q) < $signed(idex_b_q)};
      default:         ex_wd = '0;
    endcase
  end

  // The register file is written on the same edge ID reads it, so the EX
  // result is bypassed; a pending write to $0 is never forwarded.
  always_comb begin
    id_rs_val = (id_rs == 2'd0) ? '0 : rf_q[id_rs];
    id_rt_val = (id_rt == 2'd0) ? '0 : rf_q[id_rt];
    if (idex_rw_q && (idex_wr_q != 2'd0) && (idex_wr_q == id_rs)) id_rs_val = ex_wd;
    if (idex_rw_q && (idex_wr_q != 2'd0) && (idex_wr_q == id_rt)) id_rt_val = ex_wd;
  end

  always_comb begin
    pc_d       = pc_q;
    ifid_ir_d  = ifid_ir_q;
    ifid_pc_d  = ifid_pc_q;
    idex_ir_d  = idex_ir_q;
    idex_pc_d  = idex_pc_q;
    idex_a_d   = idex_a_q;
    idex_b_d   = idex_b_q;
    idex_imm_d = idex_imm_q;
    idex_rw_d  = idex_rw_q;
    idex_wr_d  = idex_wr_q;
    if (bus.run) begin
      pc_d       = pc_q + PC_STEP;
      ifid_ir_d  = bus.imem_data;
      ifid_pc_d  = pc_q;
      idex_ir_d  = ifid_ir_q;
      idex_pc_d  = ifid_pc_q;
      idex_a_d   = id_rs_val;
      idex_b_d   = (id_op == OP_ADDI) ? id_imm : id_rt_val;
      idex_imm_d = id_imm;
      idex_rw_d  = writes_reg(id_op);
      idex_wr_d  = (id_op == OP_ADDI) ? id_rt : id_rd;
      // Taken branch squashes both younger instructions into nops.
      if (ex_taken) begin
        pc_d       = ex_target;
        ifid_ir_d  = '0;
        idex_ir_d  = '0;
        idex_a_d   = '0;
        idex_b_d   = '0;
        idex_imm_d = '0;
        idex_rw_d  = 1'b0;
        idex_wr_d  = 2'd0;
      end
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      ifid_ir_q  <= '0;
      ifid_pc_q  <= '0;
      idex_ir_q  <= '0;
      idex_pc_q  <= '0;
      idex_a_q   <= '0;
      idex_b_q   <= '0;
      idex_imm_q <= '0;
      idex_rw_q  <= 1'b0;
      idex_wr_q  <= 2'd0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      ifid_ir_q  <= ifid_ir_d;
      ifid_pc_q  <= ifid_pc_d;
      idex_ir_q  <= idex_ir_d;
      idex_pc_q  <= idex_pc_d;
      idex_a_q   <= idex_a_d;
      idex_b_q   <= idex_b_d;
      idex_imm_q <= idex_imm_d;
      idex_rw_q  <= idex_rw_d;
      idex_wr_q  <= idex_wr_d;
      if (bus.run && idex_rw_q && (idex_wr_q != 2'd0)) rf_q[idex_wr_q] <= ex_wd;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.ifid_ir   = ifid_ir_q;
  assign bus.idex_ir   = idex_ir_q;
  assign bus.wd        = ex_wd;
  assign bus.wr        = idex_wr_q;
  assign bus.we        = idex_rw_q & bus.run;
endmodule

// File: doc/pipe3_core_p.md
# pipe3_core_p

Parametrised successor to the 16-bit three-stage (IF/ID/EX) MIPS-subset pipeline. Data width is configurable, and EX→ID result forwarding removes the need for nops between dependent instructions. BEQ/BNE are resolved in EX with flush. A `run` input freezes the pipeline. Instruction memory is external; the block is the CPU core instantiated by the top-level test harness.

## Interface
- `DW`, 16: datapath, register and PC width (≥16).
- `RESET_PC`, 0: PC value loaded on reset (must be even).
- `clock`  in  1  single clock; all state updates on the falling edge.
- `reset`  in  1  synchronous, active-high; sampled on the falling edge of `clock`.
- `run`  in  1  1 = pipeline advances; 0 = all state holds.
- `imem_data`  in  16  instruction at `imem_addr`; combinational read, valid in the same cycle.
- `imem_addr`  out  DW  byte address of the fetch, equal to `pc`; memory indexes `pc>>1`.
- `pc`  out  DW  current fetch PC.
- `ifid_ir`  out  16  IF/ID instruction register.
- `idex_ir`  out  16  ID/EX instruction register.
- `wd`  out  DW  EX result (write data).
- `wr`  out  2  destination register of the EX instruction.
- `we`  out  1  register write occurs at the next falling edge (`IDEX_RegWrite & run`).

## Operation
- Instruction fields: op[15:12], rs[11:10], rt[9:8], rd[7:6], imm[7:0]. `imm` is sign-extended to DW.
- Register file: 4 × DW. `$0` reads 0 and ignores writes. It has 2 read ports (rs, rt) and 1 write port.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0111 SLT: rd ← rs op rt.
  - 0100 ADDI: rt ← rs + imm.
  - 1000 BEQ, 1001 BNE: compare rs with rt; no register write.
  - 0101, 0110, 1010–1111: treated as nop (no write, no branch).
- Arithmetic: DW-bit two's-complement with wrap-around; no overflow flag. SLT is a signed compare giving 1 or 0 in DW bits. AND/OR are bitwise.
- IF: `ifid_ir ← imem_data`, `pc ← pc + 2`.
- ID: decode, read registers, then `idex_* ← {control, operands, imm, rs/rt/rd, ifid_ir}`.
- EX: ALU produces `wd`. On the same falling edge that advances ID/EX, `wd` is written to `wr` if RegWrite.
- Forwarding: each ID read operand takes `wd` instead of the register value when IDEX_RegWrite=1, `wr` equals that source, and `wr`≠0. rs and rt are checked independently. No stall is ever needed.
- Branch: taken when (BEQ and rs==rt) or (BNE and rs≠rt), evaluated in EX on forwarded-correct operands.
  - Target = (branch PC + 2) + (imm << 1), modulo 2^DW. The branch PC is carried in the ID/EX register.
  - When taken: `pc ← target`, `ifid_ir ← 0`, ID/EX ← nop. Both younger instructions are squashed (2-cycle penalty).
  - When not taken: no effect.
- Nop encoding is 0x0000 (ADD $0,$0,$0). It is harmless because `$0` is hardwired.
- `run`=0: PC, IF/ID, ID/EX and the register file hold. The EX instruction writes exactly once, on the first edge with `run`=1.
- Reset is synchronous and overrides `run`: `pc`=RESET_PC, `ifid_ir`=0, `idex_ir`=0, all ID/EX controls 0, registers $1–$3 = 0.

## Timing
- Reset values: `pc`=RESET_PC, `imem_addr`=RESET_PC, `ifid_ir`=0, `idex_ir`=0, `wr`=0, `we`=0, `wd`=0 (nop result).
- Latency: an instruction fetched at falling edge k is in ID/EX after edge k+1. Its result is visible on `wd` during cycle k+1→k+2 and is written at edge k+2.
- A dependent instruction directly behind receives the forwarded value with zero bubbles.
- Taken branch at edge e: the target instruction is in IF/ID after e+1.
- Branch in EX while `run`=0: the decision is held and applied only at the next `run`=1 edge.
- Reset asserted mid-branch or mid-write: reset wins and no write occurs at that edge.
- PC increment and branch targets wrap modulo 2^DW.

## Test plan
- Reset: hold `reset` for 2 edges → `pc`=0, `ifid_ir`=0, `idex_ir`=0, `we`=0. Then release with `run`=1 → `pc` steps 0, 2, 4.
- Back-to-back dependencies, no nops:
  - Program: addi $1,$0,15; addi $2,$0,7; and $3,$1,$2; sub $2,$1,$3; or $2,$2,$3; add $3,$2,$3; slt $1,$3,$2; slt $1,$2,$3.
  - Required `wd` sequence: 0x000F, 0x0007, 0x0007, 0x0008, 0x000F, 0x0016, 0x0000, 0x0001.
- Branch: addi $1,$0,1; beq $1,$1,+2; addi $2,$0,5; addi $2,$0,6; addi $3,$0,9.
  - Required: $2 never written, `ifid_ir`=0 the cycle after resolution, $3=9.
  - With bne in place of beq, $2 ends at 6.
- Freeze: deassert `run` for 3 cycles while addi $1,$0,3 is in EX → `pc` and both IRs stable, `we`=0. Then $1=3, written exactly once after `run` returns.
- Width/wrap: `DW`=32, addi $1,$0,-1 then add $1,$1,$1 → `wd`=0xFFFFFFFF, then 0xFFFFFFFE. slt $2,$1,$0 → 1.
- $0 protection: addi $0,$0,5 then add $1,$0,$0 → `wd`=5 for the first instruction, but $1=0 (no forwarding from a write to $0).
